// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: BRESP codes, default ID widths and a
// width helper for round-robin pointers.
package axi_ic_pkg;

    localparam int unsigned AXI_ID_W  = 4;
    localparam int unsigned AXI_MID_W = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    // Ceiling log2, never below 1 so a pointer register is never zero-width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     - request vector
//   ptr     - highest-priority index (must be < N)
//   en      - grant enable; no grant is issued when low
//   gnt     - one-hot grant (zero when no grant)
//   gnt_idx - binary index of the grant (zero when no grant)
//   any     - a grant was issued
module rr_arbiter
    import axi_ic_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    // Scan N positions starting at ptr, wrapping past N-1; first hit wins.
    always_comb begin
        int unsigned w_pos;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = 32'(ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (en && !any && req[w_pos]) begin
                gnt[w_pos] = 1'b1;
                gnt_idx    = PTR_W'(w_pos);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_resp_arb.sv
// AXI B-channel return path for one master port: round-robin selection among
// slave responses whose ID master field matches sel, held in an output register.
// Ports:
//   aclk, areset      - clock, asynchronous active-high reset
//   sel               - master index served by this instance
//   bid_m/bresp_m/bvalid_m (registered), bready_m - master-side B channel
//   bid_s/bresp_s/bvalid_s (packed per slave), bready_s (one-hot or zero)
module wr_resp_arb
    import axi_ic_pkg::*;
#(
    parameter int unsigned NUM_S = 4,
    parameter int unsigned ID_W  = AXI_ID_W,
    parameter int unsigned MID_W = AXI_MID_W
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [MID_W-1:0]        sel,
    output logic [ID_W-1:0]         bid_m,
    output logic [1:0]              bresp_m,
    output logic                    bvalid_m,
    input  logic                    bready_m,
    input  logic [NUM_S*ID_W-1:0]   bid_s,
    input  logic [NUM_S*2-1:0]      bresp_s,
    input  logic [NUM_S-1:0]        bvalid_s,
    output logic [NUM_S-1:0]        bready_s
);

    localparam int unsigned PTR_W = clog2(NUM_S);

    logic [ID_W-1:0]  r_bid;
    logic [1:0]       r_bresp;
    logic             r_bvalid;
    logic [PTR_W-1:0] r_ptr;

    logic [NUM_S-1:0] w_req;
    logic [NUM_S-1:0] w_gnt;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_any;
    logic             w_free;
    logic             w_en;
    logic [ID_W-1:0]  w_bid_sel;
    logic [1:0]       w_bresp_sel;

    // Only responses routed back to this master are candidates.
    always_comb begin
        w_req = '0;
        for (int unsigned i = 0; i < NUM_S; i++) begin
            w_req[i] = bvalid_s[i] && (bid_s[i*ID_W + ID_W - 1 -: MID_W] == sel);
        end
    end

    // A response draining this cycle frees the slot for a new one.
    assign w_free = !r_bvalid || bready_m;
    assign w_en   = w_free && !areset;

    rr_arbiter #(
        .N       (NUM_S)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_ptr),
        .en      (w_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign w_bid_sel   = bid_s[32'(w_gnt_idx)*ID_W +: ID_W];
    assign w_bresp_sel = bresp_s[32'(w_gnt_idx)*2 +: 2];

    // Output register and round-robin pointer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_bid    <= '0;
            r_bresp  <= '0;
            r_bvalid <= 1'b0;
            r_ptr    <= '0;
        end else if (w_any) begin
            r_bid    <= w_bid_sel;
            r_bresp  <= w_bresp_sel;
            r_bvalid <= 1'b1;
            r_ptr    <= (w_gnt_idx == PTR_W'(NUM_S - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
        end else if (bready_m) begin
            r_bvalid <= 1'b0;
        end
    end

    assign bready_s = w_gnt;
    assign bid_m    = r_bid;
    assign bresp_m  = r_bresp;
    assign bvalid_m = r_bvalid;

endmodule

// File: tb/tb_wr_resp_arb.sv
// Randomized and directed bench for wr_resp_arb, with a 4-slave and a 3-slave
// instance sharing the slave-side stimulus (the 3-slave one sees slaves 0..2).
module tb_wr_resp_arb;
    import axi_ic_pkg::*;

    logic        aclk;
    logic        areset;
    logic [1:0]  sel;
    logic        bready_m;
    logic [15:0] bid_s;
    logic [7:0]  bresp_s;
    logic [3:0]  bvalid_s;

    logic [3:0]  bid_m4;
    logic [1:0]  bresp_m4;
    logic        bvalid_m4;
    logic [3:0]  bready_s4;
    logic [3:0]  bid_m3;
    logic [1:0]  bresp_m3;
    logic        bvalid_m3;
    logic [2:0]  bready_s3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state per instance: held response and next-priority slave.
    bit         m_v    [2];
    logic [3:0] m_id   [2];
    logic [1:0] m_resp [2];
    int         m_ptr  [2];

    wr_resp_arb #(.NUM_S(4), .ID_W(4), .MID_W(2)) u_dut4 (
        .aclk     (aclk),
        .areset   (areset),
        .sel      (sel),
        .bid_m    (bid_m4),
        .bresp_m  (bresp_m4),
        .bvalid_m (bvalid_m4),
        .bready_m (bready_m),
        .bid_s    (bid_s),
        .bresp_s  (bresp_s),
        .bvalid_s (bvalid_s),
        .bready_s (bready_s4)
    );

    wr_resp_arb #(.NUM_S(3), .ID_W(4), .MID_W(2)) u_dut3 (
        .aclk     (aclk),
        .areset   (areset),
        .sel      (sel),
        .bid_m    (bid_m3),
        .bresp_m  (bresp_m3),
        .bvalid_m (bvalid_m3),
        .bready_m (bready_m),
        .bid_s    (bid_s[11:0]),
        .bresp_s  (bresp_s[5:0]),
        .bvalid_s (bvalid_s[2:0]),
        .bready_s (bready_s3)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k]    = 1'b0;
            m_id[k]   = '0;
            m_resp[k] = '0;
            m_ptr[k]  = 0;
        end
    endtask

    // Expected slave acknowledge for the current inputs, then advance the
    // reference to what the coming clock edge should leave in the output.
    task automatic model_cycle(input int k);
        int         n;
        int         g;
        int         s;
        bit         free;
        logic [3:0] exp_gnt;
        logic [3:0] got_gnt;
        n    = (k == 0) ? 4 : 3;
        free = !m_v[k] || bready_m;
        g    = -1;
        if (free) begin
            for (int j = 0; j < n; j++) begin
                s = (m_ptr[k] + j) % n;
                if (g < 0 && bvalid_s[s] && bid_s[s*4+3 -: 2] == sel) g = s;
            end
        end
        exp_gnt = (g >= 0) ? 4'(1 << g) : 4'd0;
        got_gnt = (k == 0) ? bready_s4 : {1'b0, bready_s3};
        chk($sformatf("bready_s_n%0d", n), 32'(got_gnt), 32'(exp_gnt));
        if (g >= 0) begin
            m_id[k]   = bid_s[g*4 +: 4];
            m_resp[k] = bresp_s[g*2 +: 2];
            m_v[k]    = 1'b1;
            m_ptr[k]  = (g + 1) % n;
        end else if (free && bready_m) begin
            m_v[k] = 1'b0;
        end
    endtask

    task automatic check_outs();
        chk("bvalid_m_n4", 32'(bvalid_m4), 32'(m_v[0]));
        chk("bid_m_n4",    32'(bid_m4),    32'(m_id[0]));
        chk("bresp_m_n4",  32'(bresp_m4),  32'(m_resp[0]));
        chk("bvalid_m_n3", 32'(bvalid_m3), 32'(m_v[1]));
        chk("bid_m_n3",    32'(bid_m3),    32'(m_id[1]));
        chk("bresp_m_n3",  32'(bresp_m3),  32'(m_resp[1]));
    endtask

    // Inputs are already driven (just after a rising edge).
    task automatic cycle();
        #1;
        model_cycle(0);
        model_cycle(1);
        @(posedge aclk);
        #1;
        check_outs();
    endtask

    task automatic set_slave(input int i, input bit v, input logic [3:0] id, input logic [1:0] rsp);
        bvalid_s[i]       = v;
        bid_s[i*4 +: 4]   = id;
        bresp_s[i*2 +: 2] = rsp;
    endtask

    initial begin
        logic [3:0] held_id;
        areset   = 1'b1;
        sel      = 2'd0;
        bready_m = 1'b0;
        bid_s    = '0;
        bresp_s  = '0;
        bvalid_s = '0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_outs();
        chk("reset_bready_s_n4", 32'(bready_s4), 32'd0);
        areset = 1'b0;

        // Single response from slave 2 with SLVERR.
        sel      = 2'd1;
        bready_m = 1'b1;
        set_slave(2, 1'b1, 4'b0110, RESP_SLVERR);
        #1;
        chk("single_bready", 32'(bready_s4), 32'h4);
        cycle();
        chk("single_bid",    32'(bid_m4),    32'h6);
        chk("single_bresp",  32'(bresp_m4),  32'h2);
        chk("single_bvalid", 32'(bvalid_m4), 32'h1);
        bvalid_s = '0;
        cycle();

        // All slaves requesting with matching IDs: one beat per cycle.
        for (int i = 0; i < 4; i++) set_slave(i, 1'b1, 4'(4 + i), 2'(i));
        repeat (6) cycle();

        // Backpressure: output must hold while bready_m is low.
        bready_m = 1'b0;
        cycle();
        held_id = bid_m4;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("bp_hold_bid", 32'(bid_m4), 32'(held_id));
        end
        bready_m = 1'b1;
        repeat (3) cycle();

        // Non-matching response stays pending until sel matches.
        bvalid_s = '0;
        sel      = 2'd0;
        set_slave(1, 1'b1, 4'b1101, RESP_DECERR);
        repeat (4) cycle();
        chk("filter_no_valid", 32'(bvalid_m4), 32'd0);
        sel = 2'd3;
        cycle();
        chk("filter_grant_bid", 32'(bid_m4), 32'hd);
        bvalid_s = '0;
        cycle();

        // Reset while a response is held under backpressure.
        bready_m = 1'b0;
        set_slave(0, 1'b1, 4'b1111, RESP_EXOKAY);
        cycle();
        #2;
        areset = 1'b1;
        #1;
        chk("rst_bvalid",   32'(bvalid_m4), 32'd0);
        chk("rst_bid",      32'(bid_m4),    32'd0);
        chk("rst_bresp",    32'(bresp_m4),  32'd0);
        chk("rst_bready_s", 32'(bready_s4), 32'd0);
        model_reset();
        @(posedge aclk);
        #1;
        areset   = 1'b0;
        bvalid_s = '0;
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(15) == 0) sel = 2'($urandom);
            bvalid_s = 4'($urandom);
            bid_s    = 16'($urandom);
            bresp_s  = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(1) == 1) bid_s[i*4+3 -: 2] = sel;
            end
            bready_m = ($urandom_range(3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
